// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU select sequencer: ALU select codes, RV32 opcode/funct7
// values, FSM state encodings and the base funct3 decode used by R-type and I-type ops.
package alu_op_sequencer_pkg;

    // ALU operation select codes, also consumed by the ALU itself
    localparam logic [3:0] ALU_SLL     = 4'b0000;
    localparam logic [3:0] ALU_SRL     = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_AND     = 4'b0011;
    localparam logic [3:0] ALU_OR      = 4'b0100;
    localparam logic [3:0] ALU_XOR     = 4'b0101;
    localparam logic [3:0] ALU_SLTU    = 4'b0110;
    localparam logic [3:0] ALU_MUL     = 4'b0111;
    localparam logic [3:0] ALU_MULHU16 = 4'b1000;
    localparam logic [3:0] ALU_DIVU    = 4'b1001;
    localparam logic [3:0] ALU_REMU    = 4'b1010;
    localparam logic [3:0] ALU_SUB     = 4'b1011;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct7 variants
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HOLD = 2'b01;
    localparam logic [1:0] ST_OUT  = 2'b10;

    // How long the ALU needs the select held
    typedef enum logic [1:0] {
        CLS_SINGLE = 2'b00,
        CLS_MUL    = 2'b01,
        CLS_DIV    = 2'b10
    } op_class_e;

    // Base funct3 map shared by R-type (funct7=0) and I-type ops; returns {illegal, sel}.
    // SLT/SLTI (010) are not supported and come back illegal with sel=ADD.
    function automatic logic [4:0] base_f3_decode(input logic [2:0] f3);
        logic [4:0] r;
        case (f3)
            3'b000:  r = {1'b0, ALU_ADD};
            3'b001:  r = {1'b0, ALU_SLL};
            3'b011:  r = {1'b0, ALU_SLTU};
            3'b100:  r = {1'b0, ALU_XOR};
            3'b101:  r = {1'b0, ALU_SRL};
            3'b110:  r = {1'b0, ALU_OR};
            3'b111:  r = {1'b0, ALU_AND};
            default: r = {1'b1, ALU_ADD};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of RV32IM instruction fields into an ALU select code, an
// illegal flag, a branch flag and the multicycle class of the operation.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_sel,
    output logic       o_illegal,
    output logic       o_is_branch,
    output op_class_e  o_op_class
);

    logic [4:0] w_base;

    // Decode opcode/funct fields; anything unsupported falls back to ADD with illegal set
    always_comb begin
        w_base      = base_f3_decode(i_funct3);
        o_sel       = ALU_ADD;
        o_illegal   = 1'b0;
        o_is_branch = 1'b0;
        o_op_class  = CLS_SINGLE;
        case (i_opcode)
            OP_R: begin
                case (i_funct7)
                    F7_BASE: {o_illegal, o_sel} = w_base;
                    F7_ALT: begin
                        // Only SUB lives here; SRA is not supported
                        if (i_funct3 == 3'b000) o_sel = ALU_SUB;
                        else                    o_illegal = 1'b1;
                    end
                    F7_MULDIV: begin
                        case (i_funct3)
                            3'b000: begin o_sel = ALU_MUL;     o_op_class = CLS_MUL; end
                            3'b001: begin o_sel = ALU_MULHU16; o_op_class = CLS_MUL; end
                            3'b101: begin o_sel = ALU_DIVU;    o_op_class = CLS_DIV; end
                            3'b111: begin o_sel = ALU_REMU;    o_op_class = CLS_DIV; end
                            default: o_illegal = 1'b1;
                        endcase
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_I: begin
                // Immediate shifts need a clean funct7, which rules out SRAI
                if ((i_funct3 == 3'b001 || i_funct3 == 3'b101) && i_funct7 != F7_BASE) begin
                    o_illegal = 1'b1;
                end else begin
                    {o_illegal, o_sel} = w_base;
                end
            end
            OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: o_sel = ALU_ADD;
            OP_BRANCH: begin
                o_sel       = ALU_SUB;
                o_is_branch = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
        if (o_illegal) begin
            o_sel      = ALU_ADD;
            o_op_class = CLS_SINGLE;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-stage sequencer: accepts one decoded instruction per handshake, registers the ALU
// select and holds it across a multicycle window for MUL/DIV codes before flagging it valid.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_sel,
    output logic       sel_valid,
    input  logic       out_ready,
    output logic       illegal,
    output logic       is_branch,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_sel;
    logic             r_illegal;
    logic             r_is_branch;

    logic [3:0] w_dec_sel;
    logic       w_dec_illegal;
    logic       w_dec_is_branch;
    op_class_e  w_dec_class;
    logic       w_in_ready;
    logic       w_accept;

    alu_op_decode u_decode (
        .i_opcode    (opcode),
        .i_funct3    (funct3),
        .i_funct7    (funct7),
        .o_sel       (w_dec_sel),
        .o_illegal   (w_dec_illegal),
        .o_is_branch (w_dec_is_branch),
        .o_op_class  (w_dec_class)
    );

    // Ready in IDLE, or in OUT when the consumer drains the current result this cycle
    assign w_in_ready = !reset && ((r_state == ST_IDLE) || (r_state == ST_OUT && out_ready));
    assign w_accept   = in_valid && w_in_ready;

    // FSM, hold counter and registered decode results
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sel       <= ALU_ADD;
            r_illegal   <= 1'b0;
            r_is_branch <= 1'b0;
        end else if (w_accept) begin
            r_sel       <= w_dec_sel;
            r_illegal   <= w_dec_illegal;
            r_is_branch <= w_dec_is_branch;
            case (w_dec_class)
                CLS_MUL: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= MUL_LOAD;
                end
                CLS_DIV: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= DIV_LOAD;
                end
                default: r_state <= ST_OUT;
            endcase
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_IDLE;
                ST_HOLD: begin
                    if (r_cnt == '0) r_state <= ST_OUT;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                ST_OUT: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign alu_sel   = r_sel;
    assign illegal   = r_illegal;
    assign is_branch = r_is_branch;
    assign sel_valid = (r_state == ST_OUT);
    assign busy      = (r_state == ST_HOLD);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: scenario tasks drive instructions, a scoreboard
// queue holds the expected select/flags for each accepted instruction.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [3:0] sel;
        logic       ill;
        logic       br;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_sel;
    logic       sel_valid;
    logic       out_ready;
    logic       illegal;
    logic       is_branch;
    logic       busy;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .MUL_CYCLES (2),
        .DIV_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .alu_sel   (alu_sel),
        .sel_valid (sel_valid),
        .out_ready (out_ready),
        .illegal   (illegal),
        .is_branch (is_branch),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one clock; record an expectation if it was accepted
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] sel, input logic ill, input logic br);
        exp_t e;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        in_valid = 1'b1;
        #1;
        if (in_ready === 1'b1) begin
            e.sel = sel;
            e.ill = ill;
            e.br  = br;
            exp_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        if (exp_q.size() == 0) e = 'x;
        else                   e = exp_q.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = 7'd0;
        funct3    = 3'd0;
        funct7    = 7'd0;
        tick();
        tick();
        checks++;
        if ({alu_sel, sel_valid, illegal, is_branch, busy} !== 8'b0010_0000)
            begin failures++; $display("FAIL reset_outputs: got sel=%b v=%b ill=%b br=%b busy=%b want 0010 0 0 0 0",
                alu_sel, sel_valid, illegal, is_branch, busy); end
        checks++;
        if (in_ready !== 1'b0)
            begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1)
            begin failures++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_rtype();
        exp_t e;
        out_ready = 1'b1;
        issue(7'b0110011, 3'b000, 7'b0000000, 4'b0010, 1'b0, 1'b0);
        e = pop_exp();
        checks++;
        if (sel_valid !== 1'b1 || {alu_sel, illegal, is_branch} !== {e.sel, e.ill, e.br})
            begin failures++; $display("FAIL r_add: got v=%b sel=%b ill=%b br=%b want v=1 sel=%b ill=%b br=%b",
                sel_valid, alu_sel, illegal, is_branch, e.sel, e.ill, e.br); end
        issue(7'b0110011, 3'b111, 7'b0000000, 4'b0011, 1'b0, 1'b0);
        e = pop_exp();
        checks++;
        if (sel_valid !== 1'b1 || {alu_sel, illegal, is_branch} !== {e.sel, e.ill, e.br})
            begin failures++; $display("FAIL r_and: got v=%b sel=%b want v=1 sel=%b",
                sel_valid, alu_sel, e.sel); end
        tick();
        checks++;
        if (sel_valid !== 1'b0 || alu_sel !== 4'b0011 || in_ready !== 1'b1)
            begin failures++; $display("FAIL idle_retain: got v=%b sel=%b rdy=%b want v=0 sel=0011 rdy=1",
                sel_valid, alu_sel, in_ready); end
    endtask

    task automatic test_divu_hold();
        exp_t e;
        out_ready = 1'b1;
        issue(7'b0110011, 3'b101, 7'b0000001, 4'b1001, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (busy !== 1'b1 || sel_valid !== 1'b0 || alu_sel !== 4'b1001 || in_ready !== 1'b0)
                begin failures++; $display("FAIL divu_hold_c%0d: got busy=%b v=%b sel=%b rdy=%b want 1 0 1001 0",
                    c, busy, sel_valid, alu_sel, in_ready); end
            if (c == 2) begin
                // Offer an ADD mid-hold; it must be ignored
                opcode   = 7'b0110011;
                funct3   = 3'b000;
                funct7   = 7'b0000000;
                in_valid = 1'b1;
            end
            if (c == 3) in_valid = 1'b0;
            tick();
        end
        e = pop_exp();
        checks++;
        if (sel_valid !== 1'b1 || busy !== 1'b0 || {alu_sel, illegal, is_branch} !== {e.sel, e.ill, e.br})
            begin failures++; $display("FAIL divu_done: got v=%b busy=%b sel=%b want v=1 busy=0 sel=%b",
                sel_valid, busy, alu_sel, e.sel); end
        tick();
        checks++;
        if (sel_valid !== 1'b0 || exp_q.size() != 0)
            begin failures++; $display("FAIL divu_no_extra: got v=%b pending=%0d want v=0 pending=0",
                sel_valid, exp_q.size()); end
    endtask

    task automatic test_mul_latency();
        logic [2:0] f3s [2] = '{3'b001, 3'b111};
        logic [3:0] sels [2] = '{4'b1000, 4'b1010};
        int         lats [2] = '{3, 5};
        exp_t e;
        int   n;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(7'b0110011, f3s[i], 7'b0000001, sels[i], 1'b0, 1'b0);
            n = 1;
            while (sel_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (n != lats[i])
                begin failures++; $display("FAIL mc_latency_%0d: got %0d cycles want %0d", i, n, lats[i]); end
            e = pop_exp();
            checks++;
            if (sel_valid !== 1'b1 || {alu_sel, illegal, is_branch} !== {e.sel, e.ill, e.br})
                begin failures++; $display("FAIL mc_result_%0d: got v=%b sel=%b want v=1 sel=%b",
                    i, sel_valid, alu_sel, e.sel); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        issue(7'b1100011, 3'b000, 7'b0000000, 4'b1011, 1'b0, 1'b1);
        e = pop_exp();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sel_valid !== 1'b1 || in_ready !== 1'b0 ||
                {alu_sel, illegal, is_branch} !== {e.sel, e.ill, e.br})
                begin failures++; $display("FAIL beq_stall_%0d: got v=%b rdy=%b sel=%b br=%b want 1 0 %b %b",
                    i, sel_valid, in_ready, alu_sel, is_branch, e.sel, e.br); end
            tick();
        end
        out_ready = 1'b1;
        issue(7'b0010011, 3'b110, 7'b0000000, 4'b0100, 1'b0, 1'b0);
        e = pop_exp();
        checks++;
        if (sel_valid !== 1'b1 || {alu_sel, illegal, is_branch} !== {e.sel, e.ill, e.br})
            begin failures++; $display("FAIL ori_after_stall: got v=%b sel=%b br=%b want v=1 sel=%b br=%b",
                sel_valid, alu_sel, is_branch, e.sel, e.br); end
        tick();
    endtask

    task automatic test_illegal();
        logic [6:0] ops [3] = '{7'b0110011, 7'b0010011, 7'b1110011};
        logic [2:0] f3s [3] = '{3'b010, 3'b101, 3'b000};
        logic [6:0] f7s [3] = '{7'b0000000, 7'b0100000, 7'b0000000};
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], f3s[i], f7s[i], 4'b0010, 1'b1, 1'b0);
            e = pop_exp();
            checks++;
            if (sel_valid !== 1'b1 || {alu_sel, illegal, is_branch} !== {e.sel, e.ill, e.br})
                begin failures++; $display("FAIL illegal_%0d: got v=%b sel=%b ill=%b want v=1 sel=%b ill=%b",
                    i, sel_valid, alu_sel, illegal, e.sel, e.ill); end
            tick();
            checks++;
            if (sel_valid !== 1'b0)
                begin failures++; $display("FAIL illegal_pulse_%0d: got v=%b want 0", i, sel_valid); end
        end
    endtask

    task automatic test_reset_mid_mul();
        int pulses = 0;
        out_ready = 1'b1;
        issue(7'b0110011, 3'b000, 7'b0000001, 4'b0111, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || alu_sel !== 4'b0111)
            begin failures++; $display("FAIL mul_hold_start: got busy=%b sel=%b want 1 0111", busy, alu_sel); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        checks++;
        if (sel_valid !== 1'b0 || busy !== 1'b0 || alu_sel !== 4'b0010)
            begin failures++; $display("FAIL mul_reset: got v=%b busy=%b sel=%b want 0 0 0010",
                sel_valid, busy, alu_sel); end
        for (int i = 0; i < 8; i++) begin
            if (sel_valid === 1'b1 || busy === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0)
            begin failures++; $display("FAIL mul_reset_quiet: got %0d active cycles want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops  [8] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                                 7'b0110011, 7'b0010011, 7'b0110111, 7'b0010011};
        logic [2:0] f3s  [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b011, 3'b111, 3'b010, 3'b101};
        logic [6:0] f7s  [8] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h2a, 7'h55, 7'h00};
        logic [3:0] sels [8] = '{4'b0010, 4'b1011, 4'b0101, 4'b0000,
                                 4'b0110, 4'b0011, 4'b0010, 4'b0001};
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], f3s[i], f7s[i], sels[i], 1'b0, 1'b0);
            e = pop_exp();
            checks++;
            if (sel_valid !== 1'b1 || {alu_sel, illegal, is_branch} !== {e.sel, e.ill, e.br})
                begin failures++; $display("FAIL b2b_%0d: got v=%b sel=%b ill=%b want v=1 sel=%b ill=%b",
                    i, sel_valid, alu_sel, illegal, e.sel, e.ill); end
        end
        tick();
        checks++;
        if (sel_valid !== 1'b0 || alu_sel !== 4'b0001)
            begin failures++; $display("FAIL b2b_drain: got v=%b sel=%b want 0 0001", sel_valid, alu_sel); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_divu_hold();
        test_mul_latency();
        test_backpressure();
        test_illegal();
        test_reset_mid_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
